// File: rtl/wb_pkg.sv
// Shared sizes and types for the writeback stage and its register banks.
package wb_pkg;

  localparam int VWIDTH    = 192;
  localparam int SWIDTH    = 32;
  localparam int NREGS     = 16;
  localparam int REG_IDX_W = 4;

  typedef logic [VWIDTH-1:0]    vec_t;
  typedef logic [SWIDTH-1:0]    scal_t;
  typedef logic [REG_IDX_W-1:0] ridx_t;

endpackage

// File: rtl/regfile_bank.sv
// One register bank: single write port, two write-first bypassed read ports,
// asynchronous clear. ZERO_R0 makes register 0 a read-only zero.
module regfile_bank #(
  parameter int WIDTH   = 32,
  parameter bit ZERO_R0 = 1'b0,
  parameter int NREGS   = 16,
  parameter int IDX_W   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [IDX_W-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [IDX_W-1:0] i_ra1,
  input  logic [IDX_W-1:0] i_ra2,
  output logic [WIDTH-1:0] o_rd1,
  output logic [WIDTH-1:0] o_rd2,
  output logic             o_wrote
);

  logic [WIDTH-1:0] r_mem [NREGS];
  logic             w_we;
  logic             w_hit1;
  logic             w_hit2;
  logic             w_zero1;
  logic             w_zero2;

  assign w_we    = i_we && !(ZERO_R0 && (i_waddr == '0));
  assign o_wrote = w_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
    end else if (w_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reset forces zero on the read side too, so a pending write cannot leak
  // through the bypass while the bank is being cleared.
  assign w_hit1  = w_we && (i_ra1 == i_waddr);
  assign w_hit2  = w_we && (i_ra2 == i_waddr);
  assign w_zero1 = rst || (ZERO_R0 && (i_ra1 == '0));
  assign w_zero2 = rst || (ZERO_R0 && (i_ra2 == '0));

  assign o_rd1 = w_zero1 ? '0 : (w_hit1 ? i_wdata : r_mem[i_ra1]);
  assign o_rd2 = w_zero2 ? '0 : (w_hit2 ? i_wdata : r_mem[i_ra2]);

endmodule

// File: rtl/writeback_regfile.sv
// Writeback stage: MemToReg select, commit to scalar and vector banks, and a
// wrapping count of cycles in which any bank was written.
module writeback_regfile
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MemToReg_in,
  input  logic        RegSWrite_in,
  input  logic        RegVWrite_in,
  input  vec_t        mem_in,
  input  vec_t        alu_in,
  input  ridx_t       RR_in,
  input  ridx_t       s_ra1,
  input  ridx_t       s_ra2,
  output scal_t       s_rd1,
  output scal_t       s_rd2,
  input  ridx_t       v_ra1,
  input  ridx_t       v_ra2,
  output vec_t        v_rd1,
  output vec_t        v_rd2,
  output logic [31:0] wb_count
);

  vec_t        w_wb_data;
  logic        w_s_wrote;
  logic        w_v_wrote;
  logic [31:0] r_wb_count;

  assign w_wb_data = MemToReg_in ? mem_in : alu_in;

  regfile_bank #(
    .WIDTH  (SWIDTH),
    .ZERO_R0(1'b1),
    .NREGS  (NREGS),
    .IDX_W  (REG_IDX_W)
  ) u_sbank (
    .clk    (clk),
    .rst    (rst),
    .i_we   (RegSWrite_in),
    .i_waddr(RR_in),
    .i_wdata(w_wb_data[SWIDTH-1:0]),
    .i_ra1  (s_ra1),
    .i_ra2  (s_ra2),
    .o_rd1  (s_rd1),
    .o_rd2  (s_rd2),
    .o_wrote(w_s_wrote)
  );

  regfile_bank #(
    .WIDTH  (VWIDTH),
    .ZERO_R0(1'b0),
    .NREGS  (NREGS),
    .IDX_W  (REG_IDX_W)
  ) u_vbank (
    .clk    (clk),
    .rst    (rst),
    .i_we   (RegVWrite_in),
    .i_waddr(RR_in),
    .i_wdata(w_wb_data),
    .i_ra1  (v_ra1),
    .i_ra2  (v_ra2),
    .o_rd1  (v_rd1),
    .o_rd2  (v_rd2),
    .o_wrote(w_v_wrote)
  );

  // A dual-bank write is a single retired writeback; dropped r0 scalar writes
  // are not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wb_count <= '0;
    end else if (w_s_wrote || w_v_wrote) begin
      r_wb_count <= r_wb_count + 32'd1;
    end
  end

  assign wb_count = r_wb_count;

endmodule
